// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external SRAM between the instruction-fetch port
// and the data port. One transaction at a time: IDLE -> ACCESS -> DONE.
// A watchdog aborts an ACCESS that never sees MRDY within TIMEOUT cycles.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin grant); when it is
// undefined the data port has fixed priority over the instruction port.
module sram_arbiter #(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction port (read-only)
  input  logic        IREQ,
  input  logic [31:0] IADDR,
  output logic        IACK,
  output logic [31:0] IDOUT,
  output logic        IERR,
  // data port
  input  logic        DREQ,
  input  logic [31:0] DADDR,
  input  logic [31:0] DDIN,
  input  logic        DWE,
  output logic        DACK,
  output logic [31:0] DDOUT,
  output logic        DERR,
  // SRAM side
  output logic [31:0] MADDR,
  output logic [31:0] MDIN,
  output logic        MWE,
  output logic        MEN,
  input  logic [31:0] MDOUT,
  input  logic        MRDY,
  // status
  output logic        BUSY
);

  localparam int unsigned DW = 32;
  // Watchdog value seen during the last allowed ACCESS cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              gnt_data_q, gnt_data_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic              men_q, men_d;
  logic              mwe_q, mwe_d;
  logic              busy_q, busy_d;
  logic              iack_q, iack_d;
  logic              dack_q, dack_d;
  logic [DW-1:0]     idout_q, idout_d;
  logic [DW-1:0]     ddout_q, ddout_d;
  logic              ierr_q, ierr_d;
  logic              derr_q, derr_d;

  logic              pick_data_c;
  logic              done_c;
  logic [DW-1:0]     res_data_c;
  logic              res_err_c;

`ifdef ARB_ROUND_ROBIN_EN
  // 1: data port wins the next simultaneous request; reset favours instruction.
  logic              prio_data_q, prio_data_d;

  // Round-robin winner selection: a lone request always wins.
  always_comb begin
    pick_data_c = DREQ && (!IREQ || prio_data_q);
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prio_data_q <= 1'b0;
    end else begin
      prio_data_q <= prio_data_d;
    end
  end
`else
  // Fixed priority: data port always beats instruction port.
  always_comb begin
    pick_data_c = DREQ;
  end
`endif

  // State, latched request and registered output flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      gnt_data_q <= 1'b0;
      wdog_q     <= '0;
      men_q      <= 1'b0;
      mwe_q      <= 1'b0;
      busy_q     <= 1'b0;
      iack_q     <= 1'b0;
      dack_q     <= 1'b0;
      idout_q    <= '0;
      ddout_q    <= '0;
      ierr_q     <= 1'b0;
      derr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      gnt_data_q <= gnt_data_d;
      wdog_q     <= wdog_d;
      men_q      <= men_d;
      mwe_q      <= mwe_d;
      busy_q     <= busy_d;
      iack_q     <= iack_d;
      dack_q     <= dack_d;
      idout_q    <= idout_d;
      ddout_q    <= ddout_d;
      ierr_q     <= ierr_d;
      derr_q     <= derr_d;
    end
  end

  // Next-state, request latching, watchdog and completion logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    gnt_data_d  = gnt_data_q;
    wdog_d      = wdog_q;
    idout_d     = idout_q;
    ddout_d     = ddout_q;
    ierr_d      = ierr_q;
    derr_d      = derr_q;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
    done_c      = 1'b0;
    res_data_c  = '0;
    res_err_c   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    prio_data_d = prio_data_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (IREQ || DREQ) begin
          gnt_data_d  = pick_data_c;
          addr_d      = pick_data_c ? DADDR : IADDR;
          wdata_d     = pick_data_c ? DDIN : '0;
          we_d        = pick_data_c && DWE;
          wdog_d      = '0;
          state_d     = S_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          prio_data_d = !pick_data_c;
`endif
        end
      end

      S_ACCESS: begin
        wdog_d = wdog_q + TMO_W'(1);
        if (MRDY) begin
          done_c     = 1'b1;
          res_data_c = MDOUT;
          res_err_c  = 1'b0;
        end else if (wdog_q == TMO_LAST) begin
          done_c     = 1'b1;
          res_data_c = '0;
          res_err_c  = 1'b1;
        end
        if (done_c) begin
          state_d = S_DONE;
          if (gnt_data_q) begin
            dack_d  = 1'b1;
            ddout_d = res_data_c;
            derr_d  = res_err_c;
          end else begin
            iack_d  = 1'b1;
            idout_d = res_data_c;
            ierr_d  = res_err_c;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SRAM strobes and status follow the state being entered.
  always_comb begin
    men_d  = (state_d == S_ACCESS);
    mwe_d  = (state_d == S_ACCESS) && we_d;
    busy_d = (state_d != S_IDLE);
  end

  assign MADDR = addr_q;
  assign MDIN  = wdata_q;
  assign MWE   = mwe_q;
  assign MEN   = men_q;
  assign BUSY  = busy_q;
  assign IACK  = iack_q;
  assign IDOUT = idout_q;
  assign IERR  = ierr_q;
  assign DACK  = dack_q;
  assign DDOUT = ddout_q;
  assign DERR  = derr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed requests push expected
// completions; a negedge monitor with an SRAM model pops and compares.
module tb_sram_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IREQ = 1'b0;
  logic [31:0] IADDR = '0;
  logic        IACK;
  logic [31:0] IDOUT;
  logic        IERR;
  logic        DREQ = 1'b0;
  logic [31:0] DADDR = '0;
  logic [31:0] DDIN = '0;
  logic        DWE = 1'b0;
  logic        DACK;
  logic [31:0] DDOUT;
  logic        DERR;
  logic [31:0] MADDR;
  logic [31:0] MDIN;
  logic        MWE;
  logic        MEN;
  logic [31:0] MDOUT;
  logic        MRDY = 1'b0;
  logic        BUSY;

  sram_arbiter #(.TMO_W(8), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .IREQ(IREQ), .IADDR(IADDR), .IACK(IACK), .IDOUT(IDOUT), .IERR(IERR),
    .DREQ(DREQ), .DADDR(DADDR), .DDIN(DDIN), .DWE(DWE),
    .DACK(DACK), .DDOUT(DDOUT), .DERR(DERR),
    .MADDR(MADDR), .MDIN(MDIN), .MWE(MWE), .MEN(MEN),
    .MDOUT(MDOUT), .MRDY(MRDY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_d;
    logic [31:0] dout;
    logic        err;
    int          men_len;
    logic        chk_dout;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // SRAM model controls: rdy_delay<0 means MRDY never comes.
  int          rdy_delay = 0;
  int          men_cnt = 0;
  int          last_men_len = 0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;

  assign MDOUT = ovr_en ? ovr_data : (MADDR + 32'h1000_0000);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic is_d, input logic [31:0] dout,
                              input logic err, input int len, input logic cd);
    exp_t e;
    e.is_d = is_d; e.dout = dout; e.err = err; e.men_len = len; e.chk_dout = cd;
    return e;
  endfunction

  // SRAM model, MEN run-length tracking and scoreboard monitor.
  always @(negedge CLK) begin
    exp_t e;
    if (MEN) begin
      men_cnt = men_cnt + 1;
      MRDY = (rdy_delay >= 0) && (men_cnt == rdy_delay + 1);
    end else begin
      if (men_cnt != 0) last_men_len = men_cnt;
      men_cnt = 0;
      MRDY = 1'b0;
    end
    if (IACK || DACK) begin
      if (IACK && DACK) begin
        n_cmp++; n_err++;
        $display("FAIL both_ack: IACK=%b DACK=%b expected one", IACK, DACK);
      end else if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_ack: IACK=%b DACK=%b expected none", IACK, DACK);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", 32'(DACK), 32'(e.is_d));
        if (e.chk_dout) chk("dout", e.is_d ? DDOUT : IDOUT, e.dout);
        chk("err", 32'(e.is_d ? DERR : IERR), 32'(e.err));
        chk("men_len", 32'(last_men_len), 32'(e.men_len));
      end
    end
  end

  task automatic wait_ack(input string nm);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (IACK || DACK) break;
    end
    if (i == 100) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no ack within 100 cycles", nm);
    end
  endtask

  initial begin
    int acks;
    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_men", 32'(MEN), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_acks", 32'({IACK, DACK, MWE}), 0);
    chk("rst_maddr", MADDR, 0);
    chk("rst_idout", IDOUT, 0);
    RST = 1'b1;
    @(negedge CLK);

    // instruction read, MRDY in first ACCESS cycle
    ovr_en = 1'b1; ovr_data = 32'h0000_0013; rdy_delay = 0;
    exp_q.push_back(mk(1'b0, 32'h0000_0013, 1'b0, 1, 1'b1));
    IREQ = 1'b1; IADDR = 32'h100;
    @(posedge CLK);
    @(negedge CLK);
    chk("t1_men", 32'(MEN), 1);
    chk("t1_maddr", MADDR, 32'h100);
    chk("t1_iack_early", 32'(IACK), 0);
    @(negedge CLK);
    chk("t1_iack", 32'(IACK), 1);
    IREQ = 1'b0; ovr_en = 1'b0;
    @(negedge CLK);
    chk("t1_iack_drop", 32'(IACK), 0);
    @(negedge CLK);

    // data write, MRDY delayed 4 cycles, DADDR changed mid-ACCESS
    rdy_delay = 4;
    exp_q.push_back(mk(1'b1, 32'h0, 1'b0, 5, 1'b0));
    DREQ = 1'b1; DADDR = 32'h200; DDIN = 32'hDEAD_BEEF; DWE = 1'b1;
    @(posedge CLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (i == 1) begin DADDR = 32'h999; DDIN = 32'h0; DWE = 1'b0; end
      chk("t2_men", 32'(MEN), 1);
      chk("t2_maddr", MADDR, 32'h200);
      chk("t2_mdin", MDIN, 32'hDEAD_BEEF);
      chk("t2_mwe", 32'(MWE), 1);
    end
    @(negedge CLK);
    chk("t2_dack", 32'(DACK), 1);
    DREQ = 1'b0;
    @(negedge CLK);
    chk("t2_mwe_off", 32'(MWE), 0);
    @(negedge CLK);

    // simultaneous requests held for four transactions
    rdy_delay = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk(1'b0, 32'h1000_0300, 1'b0, 1, 1'b1));
    exp_q.push_back(mk(1'b1, 32'h1000_0400, 1'b0, 1, 1'b1));
    exp_q.push_back(mk(1'b0, 32'h1000_0300, 1'b0, 1, 1'b1));
    exp_q.push_back(mk(1'b1, 32'h1000_0400, 1'b0, 1, 1'b1));
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 32'h1000_0400, 1'b0, 1, 1'b1));
`endif
    IREQ = 1'b1; IADDR = 32'h300;
    DREQ = 1'b1; DADDR = 32'h400; DWE = 1'b0;
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge CLK);
      if (IACK || DACK) acks++;
    end
    IREQ = 1'b0; DREQ = 1'b0;
    chk("t3_ack_count", 32'(acks), 4);
    repeat (3) @(negedge CLK);

    // watchdog timeout, then a normal request
    rdy_delay = -1;
    exp_q.push_back(mk(1'b1, 32'h0, 1'b1, 8, 1'b1));
    DREQ = 1'b1; DADDR = 32'h600;
    wait_ack("t4");
    DREQ = 1'b0;
    @(negedge CLK);
    chk("t4_idle", 32'(BUSY), 0);
    rdy_delay = 0;
    exp_q.push_back(mk(1'b0, 32'h1000_0700, 1'b0, 1, 1'b1));
    IREQ = 1'b1; IADDR = 32'h700;
    wait_ack("t4b");
    IREQ = 1'b0;
    @(negedge CLK);
    chk("t4_derr_hold", 32'(DERR), 1);
    chk("t4_ddout_hold", DDOUT, 32'h0);

    // asynchronous reset in the middle of an ACCESS
    rdy_delay = -1;
    DREQ = 1'b1; DADDR = 32'h800;
    @(posedge CLK);
    repeat (3) @(posedge CLK);
    #3 RST = 1'b0;
    #1;
    chk("t5_men", 32'(MEN), 0);
    chk("t5_busy", 32'(BUSY), 0);
    chk("t5_acks", 32'({IACK, DACK}), 0);
    chk("t5_derr", 32'(DERR), 0);
    DREQ = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    chk("t5_idle", 32'(BUSY), 0);
    rdy_delay = 1;
    exp_q.push_back(mk(1'b0, 32'h1000_0500, 1'b0, 2, 1'b1));
    IREQ = 1'b1; IADDR = 32'h500;
    wait_ack("t5b");
    IREQ = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t5_idout_hold", IDOUT, 32'h1000_0500);
    chk("t5_ddout_rst", DDOUT, 32'h0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
